// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the CPU fetch/data sides, the arbiter and the
// shared fixed-latency memory port. The arbiter takes the slave view.
// The master view covers the requesters plus the memory.
interface mem_port_arbiter_if #(
    parameter int WORD_SIZE = 16
);
    // Instruction-fetch side
    logic                 i_req;
    logic [WORD_SIZE-1:0] i_addr;
    logic                 i_done;
    logic [WORD_SIZE-1:0] i_rdata;

    // Data-access side
    logic                 d_req;
    logic                 d_we;
    logic [WORD_SIZE-1:0] d_addr;
    logic [WORD_SIZE-1:0] d_wdata;
    logic                 d_done;
    logic [WORD_SIZE-1:0] d_rdata;

    // Unified memory port
    logic                 mem_read;
    logic                 mem_write;
    logic [WORD_SIZE-1:0] mem_addr;
    logic [WORD_SIZE-1:0] mem_wdata;
    logic [WORD_SIZE-1:0] mem_rdata;

    modport slave (
        input  i_req, i_addr,
        output i_done, i_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_done, d_rdata,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output i_req, i_addr,
        input  i_done, i_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_done, d_rdata,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and data
// access. The data side wins ties. After D_STREAK_MAX back-to-back data
// grants with an instruction request still waiting, the instruction side
// is served once. Each access holds the memory command for LATENCY cycles.
// It then spends one DONE cycle pulsing the owner's done.
module mem_port_arbiter #(
    parameter int WORD_SIZE    = 16,
    parameter int LATENCY      = 2,
    parameter int D_STREAK_MAX = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    mem_port_arbiter_if.slave       bus,
    output logic                    busy,
    output logic [15:0]             num_i_grants,
    output logic [15:0]             num_d_grants
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int STR_W = (D_STREAK_MAX > 0) ? $clog2(D_STREAK_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT   = CNT_W'(LATENCY - 1);
    localparam logic [STR_W-1:0] STREAK_MAX = STR_W'(D_STREAK_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [STR_W-1:0]     r_streak;
    logic                 r_owner_d;
    logic                 r_we;
    logic [WORD_SIZE-1:0] r_addr;
    logic [WORD_SIZE-1:0] r_wdata;
    logic                 r_mem_read;
    logic                 r_mem_write;
    logic                 r_i_done;
    logic                 r_d_done;
    logic [WORD_SIZE-1:0] r_i_rdata;
    logic [WORD_SIZE-1:0] r_d_rdata;
    logic                 r_busy;
    logic [15:0]          r_i_grants;
    logic [15:0]          r_d_grants;

    logic                 w_grant_i;
    logic                 w_grant_d;

    // Grant decision in IDLE: data first, unless its streak has starved a waiting fetch.
    always_comb begin
        w_grant_i = bus.i_req && (!bus.d_req || (r_streak == STREAK_MAX));
        w_grant_d = bus.d_req && !w_grant_i;
    end

    // Arbiter FSM: all outputs are registered here so the strobes are glitch-free.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_streak    <= '0;
            r_owner_d   <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_i_done    <= 1'b0;
            r_d_done    <= 1'b0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
            r_busy      <= 1'b0;
            r_i_grants  <= '0;
            r_d_grants  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_d) begin
                        r_state     <= BUSY;
                        r_cnt       <= CNT_INIT;
                        r_busy      <= 1'b1;
                        r_owner_d   <= 1'b1;
                        r_we        <= bus.d_we;
                        r_addr      <= bus.d_addr;
                        r_wdata     <= bus.d_wdata;
                        r_mem_read  <= !bus.d_we;
                        r_mem_write <= bus.d_we;
                        r_d_grants  <= r_d_grants + 16'd1;
                        if (bus.i_req) begin
                            if (r_streak != STREAK_MAX)
                                r_streak <= r_streak + 1'b1;
                        end else begin
                            r_streak <= '0;
                        end
                    end else if (w_grant_i) begin
                        r_state     <= BUSY;
                        r_cnt       <= CNT_INIT;
                        r_busy      <= 1'b1;
                        r_owner_d   <= 1'b0;
                        r_we        <= 1'b0;
                        r_addr      <= bus.i_addr;
                        r_wdata     <= '0;
                        r_mem_read  <= 1'b1;
                        r_mem_write <= 1'b0;
                        r_i_grants  <= r_i_grants + 16'd1;
                        r_streak    <= '0;
                    end
                end
                BUSY: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_state     <= DONE;
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        if (r_owner_d) begin
                            r_d_done <= 1'b1;
                            if (!r_we)
                                r_d_rdata <= bus.mem_rdata;
                        end else begin
                            r_i_done  <= 1'b1;
                            r_i_rdata <= bus.mem_rdata;
                        end
                    end
                end
                DONE: begin
                    r_state  <= IDLE;
                    r_i_done <= 1'b0;
                    r_d_done <= 1'b0;
                    r_busy   <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Drive the bus and status outputs straight from the state registers.
    always_comb begin
        bus.i_done    = r_i_done;
        bus.i_rdata   = r_i_rdata;
        bus.d_done    = r_d_done;
        bus.d_rdata   = r_d_rdata;
        bus.mem_read  = r_mem_read;
        bus.mem_write = r_mem_write;
        bus.mem_addr  = r_addr;
        bus.mem_wdata = r_wdata;
        busy          = r_busy;
        num_i_grants  = r_i_grants;
        num_d_grants  = r_d_grants;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one LATENCY=2 instance and one
// LATENCY=1 instance. Both share the clock and the reset. Memory reads
// come from a fixed address-to-data function.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset_n;
    logic        busy2, busy1;
    logic [15:0] nI2, nD2, nI1, nD1;
    int          testsRun;
    int          testsFailed;

    mem_port_arbiter_if #(.WORD_SIZE(16)) bus2 ();
    mem_port_arbiter_if #(.WORD_SIZE(16)) bus1 ();

    mem_port_arbiter #(.WORD_SIZE(16), .LATENCY(2), .D_STREAK_MAX(4)) dut2 (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus2),
        .busy         (busy2),
        .num_i_grants (nI2),
        .num_d_grants (nD2)
    );

    mem_port_arbiter #(.WORD_SIZE(16), .LATENCY(1), .D_STREAK_MAX(4)) dut1 (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus1),
        .busy         (busy1),
        .num_i_grants (nI1),
        .num_d_grants (nD1)
    );

    // Memory contents: 0x0010 holds 0x1234, every other word is addr ^ 0xA5A5.
    function automatic logic [15:0] memModel(input logic [15:0] a);
        return (a == 16'h0010) ? 16'h1234 : (a ^ 16'hA5A5);
    endfunction

    assign bus2.mem_rdata = memModel(bus2.mem_addr);
    assign bus1.mem_rdata = memModel(bus1.mem_addr);

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        reset_n     = 1'b0;
        bus2.i_req = 0; bus2.i_addr = '0; bus2.d_req = 0; bus2.d_we = 0; bus2.d_addr = '0; bus2.d_wdata = '0;
        bus1.i_req = 0; bus1.i_addr = '0; bus1.d_req = 0; bus1.d_we = 0; bus1.d_addr = '0; bus1.d_wdata = '0;
        step();
        step();

        // Reset state
        checkOutput("rst_busy", busy2, 0);
        checkOutput("rst_strobes", {bus2.mem_read, bus2.mem_write}, 0);
        checkOutput("rst_dones", {bus2.i_done, bus2.d_done}, 0);
        checkOutput("rst_counts", {nI2, nD2}, 0);
        checkOutput("rst_rdata", {bus2.i_rdata, bus2.d_rdata}, 0);
        reset_n = 1'b1;
        step();

        // Instruction read of 0x0010
        bus2.i_req = 1; bus2.i_addr = 16'h0010;
        step();
        checkOutput("ird_c1_read", {bus2.mem_read, bus2.mem_write}, 2'b10);
        checkOutput("ird_c1_addr", bus2.mem_addr, 16'h0010);
        checkOutput("ird_c1_busy", busy2, 1);
        checkOutput("ird_c1_nI", nI2, 1);
        step();
        checkOutput("ird_c2_read", {bus2.mem_read, bus2.mem_write}, 2'b10);
        checkOutput("ird_c2_addr", bus2.mem_addr, 16'h0010);
        checkOutput("ird_c2_idone", bus2.i_done, 0);
        step();
        checkOutput("ird_c3_dones", {bus2.i_done, bus2.d_done}, 2'b10);
        checkOutput("ird_c3_rdata", bus2.i_rdata, 16'h1234);
        checkOutput("ird_c3_strobes", {bus2.mem_read, bus2.mem_write}, 0);
        bus2.i_req = 0;
        step();
        checkOutput("ird_c4_idone", bus2.i_done, 0);
        checkOutput("ird_c4_busy", busy2, 0);

        // Data read of 0x0030 so d_rdata holds a known non-zero value
        bus2.d_req = 1; bus2.d_we = 0; bus2.d_addr = 16'h0030;
        step();
        checkOutput("drd_c1_read", {bus2.mem_read, bus2.mem_write}, 2'b10);
        step();
        step();
        checkOutput("drd_c3_dones", {bus2.i_done, bus2.d_done}, 2'b01);
        checkOutput("drd_c3_rdata", bus2.d_rdata, 16'hA595);
        bus2.d_req = 0;
        step();

        // Data write of 0xBEEF to 0x0020
        bus2.d_req = 1; bus2.d_we = 1; bus2.d_addr = 16'h0020; bus2.d_wdata = 16'hBEEF;
        step();
        checkOutput("dwr_c1_write", {bus2.mem_read, bus2.mem_write}, 2'b01);
        checkOutput("dwr_c1_addr", bus2.mem_addr, 16'h0020);
        checkOutput("dwr_c1_wdata", bus2.mem_wdata, 16'hBEEF);
        bus2.d_wdata = 16'h0000;
        step();
        checkOutput("dwr_c2_write", {bus2.mem_read, bus2.mem_write}, 2'b01);
        checkOutput("dwr_c2_wdata", bus2.mem_wdata, 16'hBEEF);
        step();
        checkOutput("dwr_c3_dones", {bus2.i_done, bus2.d_done}, 2'b01);
        checkOutput("dwr_c3_rdata_kept", bus2.d_rdata, 16'hA595);
        checkOutput("dwr_c3_strobes", {bus2.mem_read, bus2.mem_write}, 0);
        bus2.d_req = 0; bus2.d_we = 0;
        step();
        checkOutput("dwr_c4_ddone", bus2.d_done, 0);
        checkOutput("dwr_counts", {nI2, nD2}, {16'd1, 16'd2});

        // Both requests raised together: D first, then I, done pulses by cycle 7
        bus2.i_req = 1; bus2.i_addr = 16'h0040;
        bus2.d_req = 1; bus2.d_we = 0; bus2.d_addr = 16'h0050;
        step();
        checkOutput("both_c1_addr", bus2.mem_addr, 16'h0050);
        step();
        step();
        checkOutput("both_c3_dones", {bus2.i_done, bus2.d_done}, 2'b01);
        checkOutput("both_c3_drdata", bus2.d_rdata, 16'hA5F5);
        bus2.d_req = 0;
        step();
        checkOutput("both_c4_idle", {busy2, bus2.i_done, bus2.d_done}, 0);
        step();
        checkOutput("both_c5_addr", bus2.mem_addr, 16'h0040);
        checkOutput("both_c5_read", bus2.mem_read, 1);
        step();
        step();
        checkOutput("both_c7_dones", {bus2.i_done, bus2.d_done}, 2'b10);
        checkOutput("both_c7_irdata", bus2.i_rdata, 16'hA5E5);
        bus2.i_req = 0;
        step();
        checkOutput("both_counts", {nI2, nD2}, {16'd2, 16'd3});

        // Streak limit: D held with I waiting gives D,D,D,D,I,D
        bus2.i_req = 1; bus2.i_addr = 16'h0070;
        bus2.d_req = 1; bus2.d_we = 0; bus2.d_addr = 16'h0060;
        for (int k = 0; k < 6; k++) begin
            step();
            checkOutput($sformatf("streak_g%0d_addr", k), bus2.mem_addr, (k == 4) ? 16'h0070 : 16'h0060);
            step();
            step();
            checkOutput($sformatf("streak_g%0d_dones", k), {bus2.i_done, bus2.d_done}, (k == 4) ? 2'b10 : 2'b01);
            if (k == 5) begin
                bus2.i_req = 0;
                bus2.d_req = 0;
            end
            step();
        end
        checkOutput("streak_counts", {nI2, nD2}, {16'd3, 16'd8});
        checkOutput("streak_idle", busy2, 0);

        // Reset during the first BUSY cycle abandons the access
        bus2.i_req = 1; bus2.i_addr = 16'h0010;
        step();
        checkOutput("rbusy_c1_read", bus2.mem_read, 1);
        reset_n = 1'b0;
        bus2.i_req = 0;
        step();
        checkOutput("rbusy_strobes", {bus2.mem_read, bus2.mem_write}, 0);
        checkOutput("rbusy_busy", busy2, 0);
        checkOutput("rbusy_counts", {nI2, nD2}, 0);
        checkOutput("rbusy_rdata", {bus2.i_rdata, bus2.d_rdata}, 0);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checkOutput($sformatf("rbusy_nodone%0d", k), {bus2.i_done, bus2.d_done}, 0);
        end

        // Fresh request after reset completes normally
        bus2.i_req = 1; bus2.i_addr = 16'h0010;
        step();
        checkOutput("fresh_c1_read", bus2.mem_read, 1);
        step();
        step();
        checkOutput("fresh_c3_idone", bus2.i_done, 1);
        checkOutput("fresh_c3_rdata", bus2.i_rdata, 16'h1234);
        bus2.i_req = 0;
        step();
        checkOutput("fresh_counts", {nI2, nD2}, {16'd1, 16'd0});

        // LATENCY=1: one strobe cycle, done in cycle 2, re-grant every 3 cycles
        bus1.i_req = 1; bus1.i_addr = 16'h0010;
        step();
        checkOutput("l1_c1_read", bus1.mem_read, 1);
        checkOutput("l1_c1_busy", busy1, 1);
        step();
        checkOutput("l1_c2_idone", bus1.i_done, 1);
        checkOutput("l1_c2_rdata", bus1.i_rdata, 16'h1234);
        checkOutput("l1_c2_read", bus1.mem_read, 0);
        step();
        checkOutput("l1_c3_idle", {busy1, bus1.mem_read, bus1.i_done}, 0);
        step();
        checkOutput("l1_c4_read", bus1.mem_read, 1);
        checkOutput("l1_c4_nI", nI1, 2);
        step();
        checkOutput("l1_c5_idone", bus1.i_done, 1);
        bus1.i_req = 0;
        step();
        checkOutput("l1_c6_idle", {busy1, bus1.mem_read}, 0);
        checkOutput("l1_counts", {nI1, nD1}, {16'd2, 16'd0});

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified, fixed-latency memory port between the pipelined CPU's instruction-fetch side and data-access side.
- Used once the CPU's separate instruction and data memory ports are merged behind caches or a single memory.
- Serialises requests and drives the memory strobes for exactly LATENCY cycles per access.
- Returns a one-cycle done pulse, plus read data, to the granted requester.
- Data side has priority; a streak limit prevents instruction-side starvation.

Parameters:
- WORD_SIZE, 16: address and data width.
- LATENCY, 2: cycles the memory command is held per access; minimum 1.
- D_STREAK_MAX, 4: maximum consecutive data grants while an instruction request is pending.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- i_req  in  1  instruction read request; held high until i_done is seen
- i_addr  in  WORD_SIZE  instruction address
- i_done  out  1  one-cycle completion pulse to the instruction side
- i_rdata  out  WORD_SIZE  instruction read data; valid while i_done=1
- d_req  in  1  data request; held high until d_done is seen
- d_we  in  1  1 = write, 0 = read
- d_addr  in  WORD_SIZE  data address
- d_wdata  in  WORD_SIZE  write data
- d_done  out  1  one-cycle completion pulse to the data side
- d_rdata  out  WORD_SIZE  data read data; valid while d_done=1 for reads
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_addr  out  WORD_SIZE  memory address
- mem_wdata  out  WORD_SIZE  memory write data
- mem_rdata  in  WORD_SIZE  memory read data; valid by the end of the LATENCY-th command cycle
- busy  out  1  1 in BUSY or DONE
- num_i_grants  out  16  instruction grant count; wraps
- num_d_grants  out  16  data grant count; wraps

Behaviour:
- Reset (reset_n=0 at a posedge): next state IDLE. Every output is 0, including all counters, the streak counter and the rdata registers. Any in-flight access is abandoned: strobes drop and no done pulse is issued.
- States:
  - IDLE: no strobes; requests are sampled.
  - BUSY: mem_* driven from latched request registers, constant for all LATENCY cycles. Exactly one of mem_read/mem_write is high.
  - DONE: one cycle; strobes low; owner's done=1.
- IDLE decision at a posedge:
  - d_req only: grant D.
  - i_req only: grant I.
  - Both: grant I if streak==D_STREAK_MAX, else grant D.
- On grant:
  - Latch addr/we/wdata and the owner.
  - cnt <= LATENCY-1.
  - Increment the owner's grant counter.
  - Streak update: I grant clears it. D grant increments it (saturating at D_STREAK_MAX) only if i_req=1, else clears it.
- BUSY: if cnt!=0, cnt decrements. If cnt==0, go to DONE; for reads, capture mem_rdata into the owner's rdata register.
- DONE: go to IDLE unconditionally; requests are not sampled in DONE.
- Latency: request high in IDLE cycle t gives strobes in cycles t+1..t+LATENCY and done in cycle t+LATENCY+1. The next grant is sampled at the end of cycle t+LATENCY+2.
- Requester contract: deassert req at the edge ending the done cycle, or hold it high to issue a new request.
- rdata registers hold their value until the next read by the same owner; writes leave d_rdata unchanged.
- Request inputs changing during BUSY have no effect.
- Non-owner done signal stays 0 throughout.
- i_done and d_done are never high in the same cycle.

Test Plan:
- LATENCY=2. Read with i_req=1, i_addr=0x0010, mem_rdata=0x1234 at that address:
  - mem_read=1 and mem_addr=0x0010 in cycles 1-2.
  - i_done=1 and i_rdata=0x1234 in cycle 3.
  - num_i_grants=1.
- Data write with d_we=1, d_addr=0x0020, d_wdata=0xBEEF:
  - mem_write=1 for 2 cycles, mem_wdata=0xBEEF.
  - d_done pulses once.
  - d_rdata unchanged.
- i_req and d_req both raised in the same IDLE cycle: D is served first, then I. Total 8 cycles to both done pulses.
- d_req held continuously with i_req=1: exactly 4 consecutive D grants, then an I grant, then D resumes. Check num_d_grants and num_i_grants.
- reset_n=0 during the first BUSY cycle:
  - Strobes are 0 the next cycle.
  - No done pulse.
  - All counters are 0.
  - A fresh request after reset completes normally.
- LATENCY=1 build: strobes last 1 cycle and done arrives in cycle 2. A back-to-back request held high re-grants every 3 cycles.
